arduino_move_rx: RTL and testbench

UART receiver and move decoder for the second player's moves, which arrive from the Arduino over one serial line. It synchronises `arduino_rx`, recovers 8N1 frames and decodes ASCII '0'..'6' into a column index. It delivers each decoded move to the game FSM and the board controller as a one-cycle `move_ready` strobe plus a held `column` value. It sits between the FPGA pin and the Connect-4 core.

---
 rtl/connect4_pkg.sv | 38 +++
 rtl/uart_rx_core.sv | 134 +++++++++++++
 rtl/arduino_move_rx.sv | 72 +++++++
 tb/tb_arduino_move_rx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board width, ASCII codes used on the
// Arduino link, the UART receiver state encoding and move-decoding helpers.
package connect4_pkg;

  localparam int NUM_COLS = 7;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  // Highest character that still names a column ('6' for a 7-wide board).
  localparam logic [7:0] ASCII_LAST = ASCII_ZERO + 8'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef logic [2:0] col_t;

  // True for the characters '0'..'6'.
  function automatic logic is_move_char(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_LAST);
  endfunction

  // Line terminators the Arduino may append after a move.
  function automatic logic is_terminator(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

  // 8-bit subtraction truncated to the column width; only meaningful
  // when is_move_char() holds for the same byte.
  function automatic col_t to_column(input logic [7:0] b);
    return col_t'(b - ASCII_ZERO);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchroniser, frame state machine and baud/bit
// counters. Reports each frame at its mid-stop sample as a byte plus a
// combinational byte_valid or frame_err strobe.
module uart_rx_core
  import connect4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208  // must be >= 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAST_CNT = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t HALF_LAST = cnt_t'(CLKS_PER_BIT / 2 - 1);

  logic       r_sync1;
  logic       r_rx_s;
  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  cnt_t       r_cnt;
  cnt_t       w_cnt_nxt;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic       w_byte_valid;
  logic       w_frame_err;

  // Two-flop synchroniser; both flops reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let r_rx_s take the old r_sync1,
      // giving two real flop stages; blocking here would collapse them.
      r_sync1 <= i_rx;
      r_rx_s  <= r_sync1;
    end
  end

  // State, counters and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state logic: half-bit start check, mid-bit data sampling, stop check.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit_idx;
    w_shift_nxt  = r_shift;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
        end
      end

      START: begin
        if (r_cnt == HALF_LAST) begin
          // Line back high at mid-start means a glitch, not a frame.
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_rx_s ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + cnt_t'(1);
        end
      end

      DATA: begin
        if (r_cnt == LAST_CNT) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};  // LSB arrives first
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + cnt_t'(1);
        end
      end

      STOP: begin
        if (r_cnt == LAST_CNT) begin
          // Back to IDLE at mid-stop so an immediate next start bit is seen.
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
          w_byte_valid = r_rx_s;
          w_frame_err  = !r_rx_s;
        end else begin
          w_cnt_nxt = r_cnt + cnt_t'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = w_byte_valid;
  assign o_frame_err  = w_frame_err;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: rtl/arduino_move_rx.sv
// Arduino move receiver: decodes ASCII '0'..'6' frames from the UART core
// into a held column plus a one-cycle move_ready strobe, gated by accept.
// Bad characters and framing errors produce a one-cycle error strobe.
module arduino_move_rx
  import connect4_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  input  logic       accept,
  output logic [2:0] column,
  output logic       move_ready,
  output logic       error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;
  logic       w_busy;
  col_t       r_column;
  logic       r_move_ready;
  logic       r_error;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (rx_data),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err),
    .o_busy      (w_busy)
  );

  // Classify each finished frame and register the move/error strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_column     <= '0;
      r_move_ready <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_move_ready <= 1'b0;
      r_error      <= 1'b0;
      if (w_frame_err) begin
        r_error <= 1'b1;
      end else if (w_byte_valid) begin
        if (is_move_char(w_byte)) begin
          // Moves arriving while the game is not waiting are dropped silently.
          if (accept) begin
            r_column     <= to_column(w_byte);
            r_move_ready <= 1'b1;
          end
        end else if (!is_terminator(w_byte)) begin
          r_error <= 1'b1;
        end
      end
    end
  end

  assign column     = r_column;
  assign move_ready = r_move_ready;
  assign error      = r_error;
  assign busy       = w_busy;

endmodule

// File: tb/tb_arduino_move_rx.sv
// Self-checking bench for arduino_move_rx at CLKS_PER_BIT = 10. A monitor
// logs every strobe; a frame-level model predicts the strobe sequence and
// the held column from the byte, stop-bit level and accept.
module tb_arduino_move_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
  // Edges from a raw start edge to the edge that raises move_ready.
  localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_data;
  logic       accept;
  logic [2:0] column;
  logic       move_ready;
  logic       error;
  logic       busy;

  arduino_move_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .accept    (accept),
    .column    (column),
    .move_ready(move_ready),
    .error     (error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int both_cnt     = 0;
  int last_start   = 0;
  int m_col        = 0;

  typedef struct {
    bit is_move;
    int col;
    int at;
  } ev_t;

  ev_t evq[$];   // observed strobes
  ev_t expq[$];  // predicted strobes

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (move_ready && error) both_cnt++;
      if (move_ready) evq.push_back('{1'b1, int'(column), cyc});
      if (error) evq.push_back('{1'b0, 0, cyc});
    end
  end

  // Outcome of one frame: 0 nothing, 1 move, 2 error.
  function automatic int model_kind(input int b, input bit stop_ok, input bit acc);
    if (!stop_ok) return 2;
    if (b >= 48 && b <= 54) return acc ? 1 : 0;
    if (b == 13 || b == 10) return 0;
    return 2;
  endfunction

  // Hold rx_data for one bit time; called on a falling edge.
  task automatic drive_bit(input logic v);
    rx_data = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Send one frame, record the model's prediction, then idle for gap cycles.
  task automatic play(input logic [7:0] b, input bit stop_ok, input int gap);
    int k;
    k = model_kind(int'(b), stop_ok, accept);
    if (k == 1) begin
      m_col = int'(b) - 48;
      expq.push_back('{1'b1, m_col, 0});
    end else if (k == 2) begin
      expq.push_back('{1'b0, 0, 0});
    end
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    rx_data = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_data = 1'b1; accept = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({column, move_ready, error, busy} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got col=%0d mr=%b err=%b busy=%b, want all 0",
               column, move_ready, error, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    accept = 1'b1;
    play(8'h36, 1'b1, 20);
    tests_run++;
    if (column !== 3'd6) begin
      tests_failed++;
      $display("FAIL reset_premove column: got %0d want 6", column);
    end
    // Start 8'h33 and stop partway through the data bits.
    rx_data = 1'b0; repeat (CPB) @(negedge clk);
    rx_data = 1'b1; repeat (CPB) @(negedge clk);
    rx_data = 1'b1; repeat (CPB) @(negedge clk);
    rx_data = 1'b0; repeat (CPB) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_busy_mid_frame: got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    m_col = 0;
    tests_run++;
    if ({column, move_ready, error, busy} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_async: got col=%0d mr=%b err=%b busy=%b, want all 0",
               column, move_ready, error, busy);
    end
    @(negedge clk);
    rx_data = 1'b1;
    @(negedge clk);
    evq.delete(); expq.delete();
    rst = 1'b0;
    repeat (200) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || evq.size() != 0 || column !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_release: got busy=%b events=%0d col=%0d, want 0/0/0",
               busy, evq.size(), column);
    end
  endtask

  task automatic test_valid_move();
    evq.delete(); expq.delete();
    accept = 1'b1;
    play(8'h34, 1'b1, 20);
    tests_run++;
    if (evq.size() != 1 || !evq[0].is_move || evq[0].col != 4) begin
      tests_failed++;
      $display("FAIL valid_4: got %0d events (first move=%0b col=%0d), want one move col 4",
               evq.size(), evq.size() > 0 ? evq[0].is_move : 1'b0,
               evq.size() > 0 ? evq[0].col : -1);
    end else begin
      tests_run++;
      if (evq[0].at - last_start < LAT_NOM || evq[0].at - last_start > LAT_NOM + 2) begin
        tests_failed++;
        $display("FAIL valid_latency: got %0d cycles want %0d..%0d",
                 evq[0].at - last_start, LAT_NOM, LAT_NOM + 2);
      end
    end
    evq.delete(); expq.delete();
    play(8'h30, 1'b1, 20);
    play(8'h36, 1'b1, 20);
    tests_run++;
    if (evq.size() != expq.size()) begin
      tests_failed++;
      $display("FAIL valid_0_6 count: got %0d events want %0d", evq.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        tests_run++;
        if (evq[i].is_move !== expq[i].is_move || evq[i].col != expq[i].col) begin
          tests_failed++;
          $display("FAIL valid_0_6 event %0d: got move=%0b col=%0d want move=%0b col=%0d",
                   i, evq[i].is_move, evq[i].col, expq[i].is_move, expq[i].col);
        end
      end
    end
    tests_run++;
    if (int'(column) != m_col) begin
      tests_failed++;
      $display("FAIL valid_hold column: got %0d want %0d", column, m_col);
    end
  endtask

  task automatic test_gated();
    evq.delete(); expq.delete();
    accept = 1'b0;
    play(8'h32, 1'b1, 20);
    tests_run++;
    if (evq.size() != 0 || int'(column) != m_col) begin
      tests_failed++;
      $display("FAIL gated_discard: got %0d events col=%0d, want 0 events col=%0d",
               evq.size(), column, m_col);
    end
    accept = 1'b1;
    play(8'h31, 1'b1, 20);
    tests_run++;
    if (evq.size() != 1 || !evq[0].is_move || evq[0].col != 1 || column !== 3'd1) begin
      tests_failed++;
      $display("FAIL gated_then_accept: got %0d events col=%0d, want one move col 1",
               evq.size(), column);
    end
  endtask

  task automatic test_bad_data();
    evq.delete(); expq.delete();
    accept = 1'b1;
    play(8'h37, 1'b1, 20);
    play(8'h41, 1'b1, 20);
    play(8'h0D, 1'b1, 20);
    tests_run++;
    if (evq.size() != 2 || evq[0].is_move || evq[1].is_move) begin
      tests_failed++;
      $display("FAIL bad_data: got %0d events, want exactly 2 error pulses", evq.size());
    end
    tests_run++;
    if (int'(column) != m_col) begin
      tests_failed++;
      $display("FAIL bad_data column: got %0d want %0d", column, m_col);
    end
  endtask

  task automatic test_framing();
    evq.delete(); expq.delete();
    accept = 1'b1;
    play(8'h33, 1'b0, 30);
    tests_run++;
    if (evq.size() != 1 || evq[0].is_move) begin
      tests_failed++;
      $display("FAIL framing_err: got %0d events, want one error pulse", evq.size());
    end
    evq.delete(); expq.delete();
    play(8'h35, 1'b1, 20);
    tests_run++;
    if (evq.size() != 1 || !evq[0].is_move || column !== 3'd5) begin
      tests_failed++;
      $display("FAIL framing_recover: got %0d events col=%0d, want one move col 5",
               evq.size(), column);
    end
  endtask

  task automatic test_glitch_back_to_back();
    evq.delete(); expq.delete();
    accept = 1'b1;
    rx_data = 1'b0;
    repeat (3) @(negedge clk);
    rx_data = 1'b1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_busy_rise: got %b want 1", busy);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || evq.size() != 0) begin
      tests_failed++;
      $display("FAIL glitch_ignored: got busy=%b events=%0d, want 0/0", busy, evq.size());
    end
    play(8'h32, 1'b1, 0);
    play(8'h34, 1'b1, 20);
    tests_run++;
    if (evq.size() != 2) begin
      tests_failed++;
      $display("FAIL back_to_back count: got %0d events want 2", evq.size());
    end else begin
      tests_run++;
      if (!evq[0].is_move || evq[0].col != 2 || !evq[1].is_move || evq[1].col != 4) begin
        tests_failed++;
        $display("FAIL back_to_back order: got cols %0d,%0d want 2,4", evq[0].col, evq[1].col);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         ok;
    evq.delete(); expq.delete();
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'($urandom_range(0, 255));
        1:       b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        default: b = 8'h30 + 8'($urandom_range(0, 7));
      endcase
      ok     = ($urandom_range(0, 5) != 0);
      accept = 1'($urandom_range(0, 1));
      play(b, ok, ok ? (($urandom_range(0, 1) != 0) ? 0 : 7) : 30);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (evq.size() != expq.size()) begin
      tests_failed++;
      $display("FAIL random count: got %0d events want %0d", evq.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        tests_run++;
        if (evq[i].is_move !== expq[i].is_move || evq[i].col != expq[i].col) begin
          tests_failed++;
          $display("FAIL random event %0d: got move=%0b col=%0d want move=%0b col=%0d",
                   i, evq[i].is_move, evq[i].col, expq[i].is_move, expq[i].col);
        end
      end
    end
    tests_run++;
    if (int'(column) != m_col || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL random final: got col=%0d busy=%b want col=%0d busy=0", column, busy, m_col);
    end
    tests_run++;
    if (both_cnt != 0) begin
      tests_failed++;
      $display("FAIL exclusive_strobes: got %0d cycles with both high, want 0", both_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_valid_move();
    test_gated();
    test_bad_data();
    test_framing();
    test_glitch_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
